// File: rtl/apb_rd_arbiter_if.sv
// apb_rd_arbiter_if: requester-side and APB-side signals of the
// two-requester APB read arbiter, bundled as one interface.
//
// Handshake: a requester raises reqN_valid with reqN_addr. In any cycle the
// arbiter is idle, a high valid is a request. The arbiter answers with a
// one-cycle reqN_ack, and the requester drops valid in that ack cycle.
// Later, a one-cycle reqN_done marks the point where reqN_rdata/reqN_err
// hold the result. Those two outputs then stay stable until that
// requester's next done.
interface apb_rd_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req0_ack;
    logic        req0_done;
    logic [31:0] req0_rdata;
    logic        req0_err;

    logic        req1_valid;
    logic [31:0] req1_addr;
    logic        req1_ack;
    logic        req1_done;
    logic [31:0] req1_rdata;
    logic        req1_err;

    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    // The arbiter: it drives the APB master signals and the requester responses.
    modport master (
        input  req0_valid, req0_addr, req1_valid, req1_addr,
        output req0_ack, req0_done, req0_rdata, req0_err,
        output req1_ack, req1_done, req1_rdata, req1_err,
        output psel, penable, paddr, pwrite,
        input  pready, pslverr, prdata
    );

    // The environment: the requesters plus the APB slave.
    modport slave (
        output req0_valid, req0_addr, req1_valid, req1_addr,
        input  req0_ack, req0_done, req0_rdata, req0_err,
        input  req1_ack, req1_done, req1_rdata, req1_err,
        input  psel, penable, paddr, pwrite,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_rd_arbiter.sv
// apb_rd_arbiter: round-robin arbiter that lets two requesters share a
// read-only APB master. Every output is registered.
//
// state_o is a debug view of the FSM:
//   0 = IDLE
//   1 = SETUP
//   2 = ACCESS
//
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles without pready. The aborted read completes with err=1 and
// rdata=0.
module apb_rd_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_rd_arbiter_if.master bus,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_q;
    logic        psel_q;
    logic        penable_q;
    logic [31:0] paddr_q;
    logic [1:0]  ack_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q [2];
    logic        last_q;      // requester granted most recently
    logic        cur_q;       // requester owning the transfer in flight

    logic        req_any_d;
    logic        gnt_d;
    logic [31:0] gnt_addr_d;
    logic        tmo_hit_d;

    // A zero timeout would mean aborting before the slave could ever answer.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("apb_rd_arbiter: TIMEOUT must be at least 1");
    end

    // Winner selection: on a tie, grant the requester not granted last time;
    // a lone requester always wins.
    always_comb begin
        gnt_d = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = bus.req1_valid;
        end
    end

    assign req_any_d  = bus.req0_valid | bus.req1_valid;
    assign gnt_addr_d = gnt_d ? bus.req1_addr : bus.req0_addr;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] tmo_cnt_q;

    // Count ACCESS cycles; the count is cleared during SETUP, so the first
    // ACCESS cycle sees zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !tmo_hit_d) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit_d = (tmo_cnt_q == CW'(TIMEOUT - 1));
`else
    assign tmo_hit_d = 1'b0;
`endif

    // Transfer FSM. The APB outputs and requester responses are updated
    // together with the state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            last_q     <= 1'b1;
            cur_q      <= 1'b0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        state_q       <= SETUP;
                        psel_q        <= 1'b1;
                        paddr_q       <= gnt_addr_d;
                        ack_q[gnt_d]  <= 1'b1;
                        last_q        <= gnt_d;
                        cur_q         <= gnt_d;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        state_q        <= IDLE;
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        done_q[cur_q]  <= 1'b1;
                        rdata_q[cur_q] <= bus.prdata;
                        err_q[cur_q]   <= bus.pslverr;
                    end else if (tmo_hit_d) begin
                        state_q        <= IDLE;
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        done_q[cur_q]  <= 1'b1;
                        rdata_q[cur_q] <= '0;
                        err_q[cur_q]   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwrite     = 1'b0;
    assign bus.req0_ack   = ack_q[0];
    assign bus.req1_ack   = ack_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_err   = err_q[0];
    assign bus.req1_err   = err_q[1];
    assign bus.req0_rdata = rdata_q[0];
    assign bus.req1_rdata = rdata_q[1];
    assign state_o        = state_q;

endmodule
